// File: rtl/maze_input_conditioner.sv
// Debounces four push-buttons and turns presses into single move requests
// with hold-to-repeat, presented on a valid/ready handshake.
module maze_input_conditioner #(
    parameter int DB_CYCLES  = 15,
    parameter int REP_DELAY  = 255,
    parameter int REP_PERIOD = 63,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       dropped,
    output logic [3:0] btn_stable
);

    localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    state_t        state;
    logic [3:0]    held;
    logic [CW-1:0] rcnt;
    logic          one_hot;
    logic          same;
    logic          req;
    logic [1:0]    req_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          level;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign btn_stable[i] = level;
    end

    assign one_hot = (btn_stable != 4'd0) &&
                     ((btn_stable & (btn_stable - 4'd1)) == 4'd0);
    assign same    = (btn_stable == held);

    always_comb begin
        req_dir = 2'd0;
        case (btn_stable)
            4'b0010: req_dir = 2'd1;
            4'b0100: req_dir = 2'd2;
            4'b1000: req_dir = 2'd3;
            default: req_dir = 2'd0;
        endcase
    end

    always_comb begin
        req = 1'b0;
        case (state)
            IDLE:    req = one_hot;
            HOLD:    req = same && (rcnt == DELAY_LAST);
            REPEAT:  req = same && (rcnt == PERIOD_LAST);
            default: req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            held       <= '0;
            rcnt       <= '0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            dropped    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state <= HOLD;
                        held  <= btn_stable;
                        rcnt  <= '0;
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state <= IDLE;
                    end else if (rcnt == DELAY_LAST) begin
                        state <= REPEAT;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!same) begin
                        state <= IDLE;
                    end else if (rcnt == PERIOD_LAST) begin
                        rcnt <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A request only lands if the output slot is free or being drained
            if (req && (!move_valid || move_ready)) begin
                move_valid <= 1'b1;
                move_dir   <= req_dir;
            end else if (req) begin
                dropped <= 1'b1;
            end else if (move_valid && move_ready) begin
                move_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maze_input_conditioner.sv
// Scoreboard bench: expected moves are queued at stimulus time and
// matched against every valid/ready handshake seen on the output.
`timescale 1ns/1ps
module tb_maze_input_conditioner;

    typedef struct {
        logic [1:0] dir;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       dropped;
    logic [3:0] btn_stable;

    int   total;
    int   bad;
    int   cyc;
    int   moves;
    exp_t sb[$];
    exp_t mon_e;

    maze_input_conditioner dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .dropped   (dropped),
        .btn_stable(btn_stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample 1ns before each rising edge: the pair the DUT is about to see
    always @(negedge clk) begin
        #4;
        if (!rst && move_valid && move_ready) begin
            moves++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_move dir=%0d cyc=%0d required=none",
                         move_dir, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (move_dir !== mon_e.dir) begin
                    bad++;
                    $display("FAIL move_dir got=%0d required=%0d cyc=%0d",
                             move_dir, mon_e.dir, cyc);
                end
                if (mon_e.cyc >= 0) begin
                    total++;
                    if (cyc !== mon_e.cyc) begin
                        bad++;
                        $display("FAIL move_time got=%0d required=%0d",
                                 cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] d, input int c);
        exp_t e;
        e.dir = d;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic check_drained(input string name, input int m0, input int n);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d required=0", name, sb.size());
        end
        total++;
        if (moves - m0 !== n) begin
            bad++;
            $display("FAIL %s_moves got=%0d required=%0d", name, moves - m0, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_raw = 4'd0;
        move_ready = 1'b0;
        step(3);
        total++;
        if ({move_valid, move_dir, dropped, btn_stable} !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=0",
                     {move_valid, move_dir, dropped, btn_stable});
        end
        rst = 1'b0;
        step(5);
        total++;
        if (move_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b required=0", move_valid);
        end
    endtask

    task automatic test_clean_press();
        int m0 = moves;
        move_ready = 1'b1;
        btn_raw = 4'b0010;
        push(2'd1, cyc + 18);
        step(100);
        btn_raw = 4'd0;
        step(40);
        check_drained("clean", m0, 1);
    endtask

    task automatic test_bounce();
        int m0 = moves;
        int last;
        for (int k = 0; k < 12; k++) begin
            btn_raw = {3'b000, (k % 2) == 0};
            step(5);
        end
        btn_raw = 4'b0001;
        last = cyc;
        push(2'd0, last + 18);
        step(16);
        total++;
        if (btn_stable !== 4'b0000) begin
            bad++;
            $display("FAIL bounce_early got=%b required=0000", btn_stable);
        end
        step(1);
        total++;
        if (btn_stable !== 4'b0001) begin
            bad++;
            $display("FAIL bounce_stable got=%b required=0001", btn_stable);
        end
        step(60);
        btn_raw = 4'd0;
        step(40);
        check_drained("bounce", m0, 1);
    endtask

    task automatic test_repeat();
        int m0 = moves;
        int c = cyc;
        btn_raw = 4'b0100;
        push(2'd2, c + 18);
        push(2'd2, c + 18 + 255);
        push(2'd2, c + 18 + 255 + 63);
        push(2'd2, c + 18 + 255 + 126);
        // Released so the stable level drops before a fourth repeat is due
        step(2 + 15 + 255 + 2 * 63 + 10);
        btn_raw = 4'd0;
        step(40);
        check_drained("repeat", m0, 4);
    endtask

    task automatic test_chord();
        int m0 = moves;
        btn_raw = 4'b1001;
        step(40);
        total++;
        if (btn_stable !== 4'b1001 || move_valid !== 1'b0) begin
            bad++;
            $display("FAIL chord got=%b/%b required=1001/0",
                     btn_stable, move_valid);
        end
        btn_raw = 4'b1000;
        push(2'd3, cyc + 18);
        step(40);
        btn_raw = 4'd0;
        step(40);
        check_drained("chord", m0, 1);
    endtask

    task automatic test_back_to_back();
        int m0 = moves;
        move_ready = 1'b0;
        btn_raw = 4'b0010;
        push(2'd1, -1);
        step(30);
        total++;
        if ({move_valid, move_dir, dropped} !== 4'b1010) begin
            bad++;
            $display("FAIL first_held got=%b required=1010",
                     {move_valid, move_dir, dropped});
        end
        btn_raw = 4'd0;
        step(30);
        btn_raw = 4'b0010;
        step(30);
        total++;
        if ({move_valid, move_dir, dropped} !== 4'b1011) begin
            bad++;
            $display("FAIL second_dropped got=%b required=1011",
                     {move_valid, move_dir, dropped});
        end
        move_ready = 1'b1;
        step(1);
        total++;
        if ({move_valid, dropped} !== 2'b01) begin
            bad++;
            $display("FAIL drain got=%b required=01", {move_valid, dropped});
        end
        btn_raw = 4'd0;
        step(40);
        total++;
        if (dropped !== 1'b1) begin
            bad++;
            $display("FAIL dropped_sticky got=%b required=1", dropped);
        end
        check_drained("b2b", m0, 1);
    endtask

    task automatic test_mid_reset();
        int m0 = moves;
        move_ready = 1'b0;
        btn_raw = 4'b0010;
        step(23);
        total++;
        if (move_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid got=%b required=1", move_valid);
        end
        rst = 1'b1;
        step(1);
        total++;
        if ({move_valid, move_dir, dropped, btn_stable} !== 8'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b required=0",
                     {move_valid, move_dir, dropped, btn_stable});
        end
        rst = 1'b0;
        move_ready = 1'b1;
        push(2'd1, cyc + 18);
        step(40);
        btn_raw = 4'd0;
        step(40);
        check_drained("mid_reset", m0, 1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        moves = 0;
        rst = 1'b1;
        btn_raw = 4'd0;
        move_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_chord();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
